sram_port_arbiter: RTL and testbench

Single-port arbiter that shares one 16-bit SRAM word bank (a pair of gf180mcu 256x8 macros) between the processor's memory port and the host loader port in the IO interface. The processor has fixed priority, and the host is guaranteed forward progress by a starvation counter that steals one cycle from the processor. The block drives the macro pins directly (active-low CEN/GWEN/WEN) and routes the synchronous read data back to whichever requester issued the read. One instance sits in front of the data memory and one in front of the instruction memory.

---
 rtl/sram_port_arbiter_if.sv | 48 ++++
 rtl/sram_port_arbiter.sv | 119 +++++++++++
 tb/tb_sram_port_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (CPU, host loader) and the SRAM macro pair.
// The slave modport is the arbiter's view; master is the requester/macro side.
interface sram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic            host_req;
  logic            host_we;
  logic [DW/8-1:0] host_be;
  logic [AW-1:0]   host_addr;
  logic [DW-1:0]   host_wdata;
  logic            host_gnt;
  logic            host_rvalid;
  logic [DW-1:0]   host_rdata;

  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_be, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
    input  sram_q
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_be, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
    output sram_q
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Fixed-priority CPU/host arbiter for one SRAM word bank; a starvation counter
// forces one host cycle after MAX_WAIT consecutive denials.
module sram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input logic                clk,
  input logic                reset,
  sram_port_arbiter_if.slave bus
);
  localparam int         NB       = DW / 8;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CPU,
    OWN_HOST,
    OWN_HOST_FORCED
  } owner_e;

  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          cpu_rd_q, cpu_rd_d;
  logic          host_rd_q, host_rd_d;
  logic          force_host;
  logic          host_gnt;
  logic          cpu_stall;
  logic          cpu_go;
  owner_e        owner;
  logic [DW-1:0] host_wen;

  logic          cen;
  logic          gwen;
  logic [DW-1:0] wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  // Byte enables expand to active-low per-bit write enables.
  for (genvar gi = 0; gi < NB; gi++) begin : g_be
    assign host_wen[gi*8 +: 8] = {8{~bus.host_be[gi]}};
  end

  always_comb begin
    force_host = bus.host_req && (wait_cnt_q == WAIT_MAX);
    host_gnt   = reset && bus.host_req && (!bus.cpu_req || force_host);
    cpu_stall  = bus.cpu_req && host_gnt;
    cpu_go     = reset && bus.cpu_req && !cpu_stall;

    owner = OWN_IDLE;
    if (host_gnt) begin
      owner = (force_host && bus.cpu_req) ? OWN_HOST_FORCED : OWN_HOST;
    end else if (cpu_go) begin
      owner = OWN_CPU;
    end
  end

  // Idle cycles park address and data at zero so the macro pins do not toggle.
  always_comb begin
    cen   = 1'b1;
    gwen  = 1'b1;
    wen   = '1;
    addr  = '0;
    wdata = '0;
    case (owner)
      OWN_CPU: begin
        cen   = 1'b0;
        gwen  = ~bus.cpu_we;
        wen   = bus.cpu_we ? '0 : '1;
        addr  = bus.cpu_addr;
        wdata = bus.cpu_wdata;
      end
      OWN_HOST, OWN_HOST_FORCED: begin
        cen   = 1'b0;
        gwen  = ~bus.host_we;
        wen   = bus.host_we ? host_wen : '1;
        addr  = bus.host_addr;
        wdata = bus.host_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.host_req || host_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    cpu_rd_d  = cpu_go && !bus.cpu_we;
    host_rd_d = host_gnt && !bus.host_we;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      cpu_rd_q   <= 1'b0;
      host_rd_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      cpu_rd_q   <= cpu_rd_d;
      host_rd_q  <= host_rd_d;
    end
  end

  assign bus.cpu_stall   = cpu_stall;
  assign bus.host_gnt    = host_gnt;
  // Gating with reset drops a read whose return cycle lands in reset.
  assign bus.cpu_rvalid  = reset && cpu_rd_q;
  assign bus.host_rvalid = reset && host_rd_q;
  assign bus.cpu_rdata   = bus.sram_q;
  assign bus.host_rdata  = bus.sram_q;

  assign bus.sram_cen  = cen;
  assign bus.sram_gwen = gwen;
  assign bus.sram_wen  = wen;
  assign bus.sram_a    = addr;
  assign bus.sram_d    = wdata;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural model of the SRAM macro pair.
module tb_sram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: registered read, bit-masked write, output held when not reading.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!bus.sram_cen) begin
      if (!bus.sram_gwen)
        mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
      else
        bus.sram_q <= mem[bus.sram_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic creq, input logic cwe,
                       input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                       input logic hreq, input logic hwe, input logic [1:0] hbe,
                       input logic [AW-1:0] haddr, input logic [DW-1:0] hwd);
    @(negedge clk);
    reset          = rst_n;
    bus.cpu_req    = creq;
    bus.cpu_we     = cwe;
    bus.cpu_addr   = caddr;
    bus.cpu_wdata  = cwd;
    bus.host_req   = hreq;
    bus.host_we    = hwe;
    bus.host_be    = hbe;
    bus.host_addr  = haddr;
    bus.host_wdata = hwd;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.sram_q = '0;

    // Reset held three cycles with both requesters active
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h3C, 16'h0, 1'b1, 1'b0, 2'b11, 8'h10, 16'h0);
      chk($sformatf("rst%0d_cen", c), 32'(bus.sram_cen), 32'd1);
      chk($sformatf("rst%0d_gnt", c), 32'(bus.host_gnt), 32'd0);
      chk($sformatf("rst%0d_stall", c), 32'(bus.cpu_stall), 32'd0);
      chk($sformatf("rst%0d_rv", c), 32'({bus.cpu_rvalid, bus.host_rvalid}), 32'd0);
      chk($sformatf("rst%0d_wen", c), 32'(bus.sram_wen), 32'hFFFF);
      chk($sformatf("rst%0d_gwen_a", c), 32'({bus.sram_gwen, bus.sram_a, bus.sram_d}), 32'h1_00_0000 >> 0 & 32'h1000000);
    end

    // Idle cycle after release
    drive(1'b1, 1'b0, 1'b0, 8'h55, 16'h1111, 1'b0, 1'b0, 2'b00, 8'h66, 16'h2222);
    chk("idle_cen", 32'(bus.sram_cen), 32'd1);
    chk("idle_a_d", 32'({bus.sram_a, bus.sram_d}), 32'h0);

    // CPU write 3C <= A55A
    drive(1'b1, 1'b1, 1'b1, 8'h3C, 16'hA55A, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0);
    chk("cwr_cen_gwen", 32'({bus.sram_cen, bus.sram_gwen}), 32'd0);
    chk("cwr_wen", 32'(bus.sram_wen), 32'h0000);
    chk("cwr_a_d", 32'({bus.sram_a, bus.sram_d}), 32'h3C_A55A);
    chk("cwr_stall", 32'(bus.cpu_stall), 32'd0);

    // CPU read 3C
    drive(1'b1, 1'b1, 1'b0, 8'h3C, 16'h0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0);
    chk("crd_cen_gwen", 32'({bus.sram_cen, bus.sram_gwen}), 32'd1);
    chk("crd_rv_early", 32'(bus.cpu_rvalid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0);
    chk("crd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("crd_rdata", 32'(bus.cpu_rdata), 32'hA55A);
    chk("crd_host_rv", 32'(bus.host_rvalid), 32'd0);

    // Preload 10 <= 1234, then host byte write of the upper byte
    drive(1'b1, 1'b1, 1'b1, 8'h10, 16'h1234, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0);
    chk("pre_cen", 32'(bus.sram_cen), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 2'b10, 8'h10, 16'hFF00);
    chk("hwr_gnt", 32'(bus.host_gnt), 32'd1);
    chk("hwr_wen", 32'(bus.sram_wen), 32'h00FF);
    chk("hwr_gwen", 32'(bus.sram_gwen), 32'd0);
    chk("hwr_a_d", 32'({bus.sram_a, bus.sram_d}), 32'h10_FF00);

    // Host write with no byte enables: granted, nothing changes
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 2'b00, 8'h10, 16'hDEAD);
    chk("hbe0_gnt", 32'(bus.host_gnt), 32'd1);
    chk("hbe0_gwen_wen", 32'({bus.sram_gwen, bus.sram_wen}), 32'h0_FFFF);

    // Host read 10
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 2'b11, 8'h10, 16'h0);
    chk("hrd_gnt", 32'(bus.host_gnt), 32'd1);
    chk("hrd_gwen_wen", 32'({bus.sram_gwen, bus.sram_wen}), 32'h1_FFFF);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0);
    chk("hrd_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("hrd_rdata", 32'(bus.host_rdata), 32'hFF34);
    chk("hrd_cpu_rv", 32'(bus.cpu_rvalid), 32'd0);

    // Starvation: CPU reads 3C continuously, host holds a read of 10
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h3C, 16'h0, 1'b1, 1'b0, 2'b11, 8'h10, 16'h0);
      chk($sformatf("stv%0d_gnt", c), 32'(bus.host_gnt), (c % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("stv%0d_stall", c), 32'(bus.cpu_stall), (c % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("stv%0d_a", c), 32'(bus.sram_a), (c % 5 == 4) ? 32'h10 : 32'h3C);
      if (c == 3)
        chk("stv3_wait", 32'(dut.wait_cnt_q), 32'd3);
      if (c == 5) begin
        chk("stv5_host_rv", 32'(bus.host_rvalid), 32'd1);
        chk("stv5_host_rd", 32'(bus.host_rdata), 32'hFF34);
        chk("stv5_cpu_rv", 32'(bus.cpu_rvalid), 32'd0);
      end
      if (c == 1 || c == 6) begin
        chk($sformatf("stv%0d_cpu_rv", c), 32'(bus.cpu_rvalid), 32'd1);
        chk($sformatf("stv%0d_cpu_rd", c), 32'(bus.cpu_rdata), 32'hA55A);
      end
    end

    // Idle-slot interleave: host wins every cycle the CPU is quiet
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, logic'(c % 2), 1'b0, 8'h3C, 16'h0, 1'b1, 1'b0, 2'b11, 8'h10, 16'h0);
      chk($sformatf("alt%0d_gnt", c), 32'(bus.host_gnt), (c % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_stall", c), 32'(bus.cpu_stall), 32'd0);
      if (c % 2 == 1)
        chk($sformatf("alt%0d_wait", c), 32'(dut.wait_cnt_q), 32'd0);
    end

    // Host read granted, then reset drops in the return cycle
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 2'b11, 8'h3C, 16'h0);
    chk("rr_gnt", 32'(bus.host_gnt), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 2'b11, 8'h3C, 16'h0);
    chk("rr_rvalid_rst", 32'(bus.host_rvalid), 32'd0);
    chk("rr_gnt_rst", 32'({bus.host_gnt, bus.cpu_stall}), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0);
    chk("rr_rvalid_post", 32'(bus.host_rvalid), 32'd0);
    chk("rr_wait_post", 32'(dut.wait_cnt_q), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
